// File: rtl/team_06_i2s_tx_if.sv
// Sample handshake plus I2S line bundle for team_06_i2s_tx.
// Handshake: sample_in is taken when sample_valid && sample_ready at a rising clk edge; sample_ready is registered.
interface team_06_i2s_tx_if #(
  parameter int SAMPLE_W = 16
) ();
  logic                en;
  logic [SAMPLE_W-1:0] sample_in;
  logic                sample_valid;
  logic                sample_ready;
  logic                bclk;
  logic                ws;
  logic                sdata;
  logic                frame_start;
  logic                underrun;

  modport master (
    output en, sample_in, sample_valid,
    input  sample_ready, bclk, ws, sdata, frame_start, underrun
  );

  modport slave (
    input  en, sample_in, sample_valid,
    output sample_ready, bclk, ws, sdata, frame_start, underrun
  );
endinterface

// File: rtl/team_06_i2s_tx.sv
// Mono I2S transmitter with a one-entry holding buffer; each sample fills both slots of a frame.
// Build macro TEAM_06_I2S_TX_HOLD_LAST_EN: on underrun repeat the last sample instead of sending silence.
module team_06_i2s_tx #(
  parameter int CLK_DIV  = 4,
  parameter int SAMPLE_W = 16,
  parameter int SLOT_W   = 32
) (
  input logic              clk,
  input logic              rst,
  team_06_i2s_tx_if.slave  bus
);
  localparam int PW = $clog2(2 * SLOT_W);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] P_LAST   = PW'(2 * SLOT_W - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0]       div_q, div_d;
  logic [PW-1:0]       p_q, p_d;
  logic                bclk_q, bclk_d;
  logic                ws_q, ws_d;
  logic                sdata_q, sdata_d;
  logic [SAMPLE_W-1:0] frame_q, frame_d;
  logic [SAMPLE_W-1:0] hold_q, hold_d;
  logic                full_q, full_d;
  logic                ready_q, ready_d;
  logic                fs_q, fs_d;
  logic                ur_q, ur_d;
  logic                load;
  int                  p_int;
  int                  bit_idx;

  always_comb begin
    div_d   = div_q;
    bclk_d  = bclk_q;
    p_d     = p_q;
    frame_d = frame_q;
    hold_d  = hold_q;
    full_d  = full_q;
    fs_d    = 1'b0;
    ur_d    = 1'b0;
    load    = 1'b0;

    if (bus.en) begin
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        bclk_d = ~bclk_q;
        if (bclk_q) begin
          p_d  = (p_q == P_LAST) ? '0 : p_q + PW'(1);
          load = (p_q == P_LAST);
        end
      end else begin
        div_d = div_q + DW'(1);
      end
    end else begin
      div_d  = '0;
      bclk_d = 1'b0;
      p_d    = P_LAST;
    end

    if (load) begin
      fs_d = 1'b1;
      if (full_q) begin
        frame_d = hold_q;
        full_d  = 1'b0;
      end else begin
        ur_d = 1'b1;
`ifdef TEAM_06_I2S_TX_HOLD_LAST_EN
        frame_d = frame_q;
`else
        frame_d = '0;
`endif
      end
    end

    // ready_q is only high while empty, so a transfer never collides with a buffered load
    if (bus.sample_valid && ready_q) begin
      hold_d = bus.sample_in;
      full_d = 1'b1;
    end
    ready_d = ~full_d;

    // Line outputs are derived from the next position so they move with bclk on the same edge
    p_int   = int'(p_d);
    ws_d    = (p_int >= SLOT_W - 1) && (p_int <= 2 * SLOT_W - 2);
    bit_idx = -1;
    if (p_int < SAMPLE_W) begin
      bit_idx = SAMPLE_W - 1 - p_int;
    end else if (p_int >= SLOT_W && p_int < SLOT_W + SAMPLE_W) begin
      bit_idx = SAMPLE_W - 1 - (p_int - SLOT_W);
    end
    sdata_d = 1'b0;
    for (int i = 0; i < SAMPLE_W; i++) begin
      if (bit_idx == i) sdata_d = frame_d[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      p_q     <= P_LAST;
      bclk_q  <= 1'b0;
      ws_q    <= 1'b0;
      sdata_q <= 1'b0;
      frame_q <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
      ready_q <= 1'b1;
      fs_q    <= 1'b0;
      ur_q    <= 1'b0;
    end else begin
      div_q   <= div_d;
      p_q     <= p_d;
      bclk_q  <= bclk_d;
      ws_q    <= ws_d;
      sdata_q <= sdata_d;
      frame_q <= frame_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      ready_q <= ready_d;
      fs_q    <= fs_d;
      ur_q    <= ur_d;
    end
  end

  assign bus.bclk         = bclk_q;
  assign bus.ws           = ws_q;
  assign bus.sdata        = sdata_q;
  assign bus.sample_ready = ready_q;
  assign bus.frame_start  = fs_q;
  assign bus.underrun     = ur_q;
endmodule
